wf68k30l_dreg_wb_scheduler: RTL and testbench
=============================================

Name: wf68k30l_dreg_wb_scheduler

Overview:
- Writeback scheduler in front of the WF68K30L data-register file.
- Shares the file's two write ports (DR_WR_1/DR_WR_2) between three result sources: ALU, load unit and MUL/DIV, where MUL/DIV may write a register pair.
- Tracks outstanding hazard-marked destinations and generates the register file's UNMARK pulse once every marked result has been written.
- All register-file write controls are registered, giving one cycle of latency from grant to write.

Parameters:
- AGE_LIMIT, 4: number of consecutive cycles an ALU request may be denied before it is promoted to top priority.
- MAX_OUT, 3: maximum number of outstanding marked destinations. The counter is 2 bits wide.

Ports:
- CLK  in  1  clock. One clock.
- RESET_N  in  1  reset. Asynchronous, active-low.
- ALU_REQ, LD_REQ  in  1  single-word writeback request.
- ALU_SEL, LD_SEL  in  3  destination Dn.
- ALU_DATA, LD_DATA  in  32  result data.
- ALU_RETIRE, LD_RETIRE  in  1  this write retires a marked destination.
- ALU_ACK, LD_ACK  out  1  combinational grant, asserted in the cycle the request is accepted.
- MD_REQ  in  1  MUL/DIV writeback request.
- MD_PAIR  in  1  request is a register-pair write (Dl and Dh).
- MD_SEL_1, MD_SEL_2  in  3  pair destinations. MD_SEL_2 is used only when MD_PAIR=1.
- MD_DATA_1, MD_DATA_2  in  32  pair data.
- MD_RETIRE  in  1  this write retires a marked destination.
- MD_ACK  out  1  combinational grant.
- MARK_ISSUE  in  1  the decoder has marked a new destination in-use.
- MARK_STALL  out  1  outstanding count equals MAX_OUT. The decoder must hold MARK_ISSUE low while this is asserted.
- DR_WR_1, DR_WR_2  out  1  registered write strobes.
- DR_SEL_WR_1, DR_SEL_WR_2  out  3  registered write selects.
- DR_IN_1, DR_IN_2  out  32  registered write data.
- UNMARK  out  1  registered one-cycle pulse to the register file.
- MARK_OVF  out  1  sticky error flag.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - All registered outputs go to 0: DR_WR_*, DR_SEL_WR_*, DR_IN_*, UNMARK, MARK_OVF.
  - Outstanding counter = 0; ALU age counter = 0.
  - ACKs are 0 while in reset.
  - Reset in the middle of a pair write drops the second-cycle state. No partial write appears after reset is released.
- Request protocol:
  - Valid/ack. A requester holds REQ, SEL, DATA and RETIRE stable until it sees ACK high at a CLK edge.
  - ACK is high only while the matching REQ is high.
  - After ACK the request counts as consumed at that edge.
- Arbitration, evaluated each cycle in priority order:
  - Order is MD, LD, ALU, except that ALU moves to first when age == AGE_LIMIT.
  - MD pair with distinct selects: consumes both ports, so only MD is granted that cycle.
  - MD pair with MD_SEL_1 == MD_SEL_2: treated as a single write of MD_DATA_1 on one port.
  - Single-word requests each take one port. At most two grants per cycle.
  - Destination conflict: a candidate whose SEL equals a destination already granted this cycle is denied.
  - The first grant uses port 1 and the second grant uses port 2.
- Age counter:
  - Increments when ALU_REQ=1 and ALU_ACK=0, saturating at AGE_LIMIT.
  - Clears on ALU_ACK or when ALU_REQ=0.
- Write path:
  - The edge after a grant: DR_WR_n=1 with the granted SEL and DATA, for exactly one cycle.
  - Unused ports drive DR_WR=0, with SEL and DATA held at their previous values.
- Outstanding counter:
  - retire_n = number of granted requests this cycle with RETIRE=1, in the range 0..2. A pair request counts as 1.
  - Next count = count + MARK_ISSUE − retire_n.
  - Simultaneous issue and retire give a net change.
  - Underflow (retire while count=0) clamps to 0 and sets MARK_OVF.
  - MARK_ISSUE while count == MAX_OUT: the increment is ignored and MARK_OVF is set.
  - MARK_OVF clears only on reset.
- UNMARK:
  - Pulses for one cycle in the cycle after the count transitions from nonzero to 0.
  - The pulse is aligned with the DR_WR strobe of the retiring write.
  - No pulse when the count stays at 0.
- MARK_STALL is combinational from the count: high when count == MAX_OUT.

Test Plan:
- Reset sequencing:
  - Stimulus: assert RESET_N=0 mid-stream with ALU_REQ=1 and LD_REQ=1 pending, then release.
  - Required: all outputs 0 during reset; the first grants occur in the first cycle after release; DR_WR_1/2 assert one cycle later.
- Dual single writes:
  - Stimulus: LD_REQ to D3 with data 0x11111111, ALU_REQ to D5 with data 0x22222222, same cycle.
  - Required: both ACK; next cycle DR_WR_1 writes D3=0x11111111 and DR_WR_2 writes D5=0x22222222.
- Pair priority and ALU aging:
  - Stimulus: MD_PAIR to D1:D2 held with back-to-back MD requests while ALU_REQ is held.
  - Required: MD is granted alone; ALU is denied for 4 cycles, then wins the 5th cycle ahead of MD.
- Destination conflict:
  - Stimulus: LD and ALU both target D4.
  - Required: only LD_ACK; ALU_ACK follows the next cycle; DR_WR_2 stays 0 in the first write cycle.
- Mark/retire counting:
  - Stimulus: 3× MARK_ISSUE.
  - Required: MARK_STALL=1 after the third. A 4th MARK_ISSUE sets MARK_OVF and the count stays 3. Three RETIRE writes bring the count to 0, and UNMARK pulses exactly once, with the last DR_WR.
- Simultaneous issue and retire:
  - Stimulus: count=1; MARK_ISSUE together with a RETIRE grant.
  - Required: count stays 1 and no UNMARK pulse.

Source files
------------

// File: rtl/wf68k30l_dreg_wb_scheduler.sv
// Writeback scheduler for the WF68K30L data-register file.
// Arbitrates ALU, load and MUL/DIV results onto the file's two write ports,
// ages starved ALU requests, and tracks hazard-marked destinations so the
// file can be told (UNMARK) when every marked result has landed.
module wf68k30l_dreg_wb_scheduler #(
  parameter int AGE_LIMIT = 4,
  parameter int MAX_OUT   = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ALU_REQ,
  input  logic [2:0]  ALU_SEL,
  input  logic [31:0] ALU_DATA,
  input  logic        ALU_RETIRE,
  output logic        ALU_ACK,
  input  logic        LD_REQ,
  input  logic [2:0]  LD_SEL,
  input  logic [31:0] LD_DATA,
  input  logic        LD_RETIRE,
  output logic        LD_ACK,
  input  logic        MD_REQ,
  input  logic        MD_PAIR,
  input  logic [2:0]  MD_SEL_1,
  input  logic [2:0]  MD_SEL_2,
  input  logic [31:0] MD_DATA_1,
  input  logic [31:0] MD_DATA_2,
  input  logic        MD_RETIRE,
  output logic        MD_ACK,
  input  logic        MARK_ISSUE,
  output logic        MARK_STALL,
  output logic        DR_WR_1,
  output logic        DR_WR_2,
  output logic [2:0]  DR_SEL_WR_1,
  output logic [2:0]  DR_SEL_WR_2,
  output logic [31:0] DR_IN_1,
  output logic [31:0] DR_IN_2,
  output logic        UNMARK,
  output logic        MARK_OVF
);

  localparam int               AGE_W   = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
  localparam logic [1:0]       CNT_MAX = 2'(MAX_OUT);

  typedef enum logic [1:0] {SRC_MD, SRC_LD, SRC_ALU} src_e;

  logic [AGE_W-1:0] age_q, age_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unmark_q, unmark_d;
  logic             wr1_q, wr2_q;
  logic [2:0]       sel1_q, sel2_q;
  logic [31:0]      in1_q, in2_q;

  logic             p1_v, p2_v;
  logic [2:0]       p1_sel, p2_sel;
  logic [31:0]      p1_data, p2_data;
  logic             md_gnt, ld_gnt, alu_gnt;
  logic [1:0]       retire_n;

  src_e             cand;
  logic             c_req, c_ret, c_dual, c_gnt;
  logic [2:0]       c_sel;
  logic [31:0]      c_data;

  logic             issue_ok;
  logic [2:0]       cnt_sum, cnt_diff;

  // Priority walk over the three sources; first grant lands on port 1.
  // A distinct-select pair only fits when both ports are still free.
  always_comb begin
    md_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    alu_gnt  = 1'b0;
    p1_v     = 1'b0;
    p1_sel   = '0;
    p1_data  = '0;
    p2_v     = 1'b0;
    p2_sel   = '0;
    p2_data  = '0;
    retire_n = '0;
    cand     = SRC_MD;
    c_req    = 1'b0;
    c_sel    = '0;
    c_data   = '0;
    c_ret    = 1'b0;
    c_dual   = 1'b0;
    c_gnt    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (age_q == AGE_MAX)
        cand = (k == 0) ? SRC_ALU : ((k == 1) ? SRC_MD : SRC_LD);
      else
        cand = (k == 0) ? SRC_MD : ((k == 1) ? SRC_LD : SRC_ALU);
      case (cand)
        SRC_MD: begin
          c_req  = MD_REQ;
          c_sel  = MD_SEL_1;
          c_data = MD_DATA_1;
          c_ret  = MD_RETIRE;
          c_dual = MD_PAIR && (MD_SEL_1 != MD_SEL_2);
        end
        SRC_LD: begin
          c_req  = LD_REQ;
          c_sel  = LD_SEL;
          c_data = LD_DATA;
          c_ret  = LD_RETIRE;
          c_dual = 1'b0;
        end
        default: begin
          c_req  = ALU_REQ;
          c_sel  = ALU_SEL;
          c_data = ALU_DATA;
          c_ret  = ALU_RETIRE;
          c_dual = 1'b0;
        end
      endcase
      c_gnt = 1'b0;
      if (c_req && RESET_N) begin
        if (c_dual) begin
          if (!p1_v) begin
            c_gnt   = 1'b1;
            p1_v    = 1'b1;
            p1_sel  = c_sel;
            p1_data = c_data;
            p2_v    = 1'b1;
            p2_sel  = MD_SEL_2;
            p2_data = MD_DATA_2;
          end
        end else if (!p2_v && !(p1_v && (c_sel == p1_sel))) begin
          c_gnt = 1'b1;
          if (!p1_v) begin
            p1_v    = 1'b1;
            p1_sel  = c_sel;
            p1_data = c_data;
          end else begin
            p2_v    = 1'b1;
            p2_sel  = c_sel;
            p2_data = c_data;
          end
        end
      end
      if (c_gnt) begin
        retire_n = retire_n + {1'b0, c_ret};
        case (cand)
          SRC_MD:  md_gnt  = 1'b1;
          SRC_LD:  ld_gnt  = 1'b1;
          default: alu_gnt = 1'b1;
        endcase
      end
    end
  end

  // ALU starvation age: counts denied cycles, saturates at the promotion point.
  always_comb begin
    age_d = '0;
    if (ALU_REQ && !alu_gnt)
      age_d = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);
  end

  // Outstanding-mark bookkeeping: net issue/retire, clamp and flag both overflow directions.
  always_comb begin
    issue_ok = MARK_ISSUE && (cnt_q != CNT_MAX);
    cnt_sum  = {1'b0, cnt_q} + {2'b00, issue_ok};
    cnt_diff = '0;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (MARK_ISSUE && (cnt_q == CNT_MAX))
      ovf_d = 1'b1;
    if ({1'b0, retire_n} > cnt_sum) begin
      cnt_d = '0;
      ovf_d = 1'b1;
    end else begin
      cnt_diff = cnt_sum - {1'b0, retire_n};
      cnt_d    = cnt_diff[1:0];
    end
    unmark_d = (cnt_q != 2'd0) && (cnt_d == 2'd0);
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      age_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unmark_q <= 1'b0;
    end else begin
      age_q    <= age_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unmark_q <= unmark_d;
    end
  end

  // Registered write ports; select/data hold when a port is idle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr1_q  <= 1'b0;
      wr2_q  <= 1'b0;
      sel1_q <= '0;
      sel2_q <= '0;
      in1_q  <= '0;
      in2_q  <= '0;
    end else begin
      wr1_q <= p1_v;
      wr2_q <= p2_v;
      if (p1_v) begin
        sel1_q <= p1_sel;
        in1_q  <= p1_data;
      end
      if (p2_v) begin
        sel2_q <= p2_sel;
        in2_q  <= p2_data;
      end
    end
  end

  assign ALU_ACK     = alu_gnt;
  assign LD_ACK      = ld_gnt;
  assign MD_ACK      = md_gnt;
  assign MARK_STALL  = (cnt_q == CNT_MAX);
  assign DR_WR_1     = wr1_q;
  assign DR_WR_2     = wr2_q;
  assign DR_SEL_WR_1 = sel1_q;
  assign DR_SEL_WR_2 = sel2_q;
  assign DR_IN_1     = in1_q;
  assign DR_IN_2     = in2_q;
  assign UNMARK      = unmark_q;
  assign MARK_OVF    = ovf_q;

endmodule

// File: tb/tb_wf68k30l_dreg_wb_scheduler.sv
// Bench for the data-register writeback scheduler: directed scenarios followed
// by random traffic, all checked against a queue-based reference model.
module tb_wf68k30l_dreg_wb_scheduler;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ALU_REQ, ALU_RETIRE, ALU_ACK;
  logic [2:0]  ALU_SEL;
  logic [31:0] ALU_DATA;
  logic        LD_REQ, LD_RETIRE, LD_ACK;
  logic [2:0]  LD_SEL;
  logic [31:0] LD_DATA;
  logic        MD_REQ, MD_PAIR, MD_RETIRE, MD_ACK;
  logic [2:0]  MD_SEL_1, MD_SEL_2;
  logic [31:0] MD_DATA_1, MD_DATA_2;
  logic        MARK_ISSUE, MARK_STALL;
  logic        DR_WR_1, DR_WR_2;
  logic [2:0]  DR_SEL_WR_1, DR_SEL_WR_2;
  logic [31:0] DR_IN_1, DR_IN_2;
  logic        UNMARK, MARK_OVF;

  always #5 CLK = ~CLK;

  wf68k30l_dreg_wb_scheduler dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .ALU_REQ(ALU_REQ), .ALU_SEL(ALU_SEL), .ALU_DATA(ALU_DATA), .ALU_RETIRE(ALU_RETIRE), .ALU_ACK(ALU_ACK),
    .LD_REQ(LD_REQ), .LD_SEL(LD_SEL), .LD_DATA(LD_DATA), .LD_RETIRE(LD_RETIRE), .LD_ACK(LD_ACK),
    .MD_REQ(MD_REQ), .MD_PAIR(MD_PAIR), .MD_SEL_1(MD_SEL_1), .MD_SEL_2(MD_SEL_2),
    .MD_DATA_1(MD_DATA_1), .MD_DATA_2(MD_DATA_2), .MD_RETIRE(MD_RETIRE), .MD_ACK(MD_ACK),
    .MARK_ISSUE(MARK_ISSUE), .MARK_STALL(MARK_STALL),
    .DR_WR_1(DR_WR_1), .DR_WR_2(DR_WR_2), .DR_SEL_WR_1(DR_SEL_WR_1), .DR_SEL_WR_2(DR_SEL_WR_2),
    .DR_IN_1(DR_IN_1), .DR_IN_2(DR_IN_2), .UNMARK(UNMARK), .MARK_OVF(MARK_OVF)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // requester state, index 0 = MD, 1 = LD, 2 = ALU
  bit          pend[3];
  logic [2:0]  rsel[3];
  logic [31:0] rdat[3];
  bit          rret[3];
  bit          md_pair;
  logic [2:0]  md_sel2;
  logic [31:0] md_dat2;
  bit          mark_issue;
  bit          auto_gen;

  // reference model state
  typedef struct {logic [2:0] sel; logic [31:0] data;} wr_t;
  int          m_age, m_cnt;
  bit          m_ovf;
  bit          e_wr1, e_wr2, e_unmark;
  logic [2:0]  e_sel1, e_sel2;
  logic [31:0] e_in1, e_in2;
  bit          m_gnt[3];
  bit          s_ack[3];

  task automatic model_reset();
    m_age = 0; m_cnt = 0; m_ovf = 0;
    e_wr1 = 0; e_wr2 = 0; e_unmark = 0;
    e_sel1 = '0; e_sel2 = '0; e_in1 = '0; e_in2 = '0;
    for (int k = 0; k < 3; k++) m_gnt[k] = 0;
  endtask

  task automatic drive();
    MD_REQ = pend[0]; MD_SEL_1 = rsel[0]; MD_DATA_1 = rdat[0]; MD_RETIRE = rret[0];
    MD_PAIR = md_pair; MD_SEL_2 = md_sel2; MD_DATA_2 = md_dat2;
    LD_REQ = pend[1]; LD_SEL = rsel[1]; LD_DATA = rdat[1]; LD_RETIRE = rret[1];
    ALU_REQ = pend[2]; ALU_SEL = rsel[2]; ALU_DATA = rdat[2]; ALU_RETIRE = rret[2];
    MARK_ISSUE = mark_issue;
  endtask

  task automatic gen();
    for (int k = 0; k < 3; k++) begin
      if (!pend[k] && ($urandom % 2 == 0)) begin
        pend[k] = 1;
        rsel[k] = 3'($urandom_range(0, 4));
        rdat[k] = $urandom;
        rret[k] = ($urandom % 3 == 0);
        if (k == 0) begin
          md_pair = ($urandom % 2 == 0);
          md_sel2 = ($urandom % 4 == 0) ? rsel[0] : 3'($urandom_range(0, 4));
          md_dat2 = $urandom;
        end
      end
    end
    mark_issue = ($urandom % 3 == 0);
  endtask

  // Compare the DUT to the model for this cycle, then advance the model past the next edge.
  task automatic model_eval();
    int   ord[3];
    int   ports;
    int   retire;
    int   nxt;
    bit   iss;
    bit   used[8];
    bit   g;
    wr_t  w;
    wr_t  wq[$];
    for (int k = 0; k < 3; k++) m_gnt[k] = 0;
    if (!RESET_N) begin
      chk("rst md_ack", MD_ACK, 0);
      chk("rst ld_ack", LD_ACK, 0);
      chk("rst alu_ack", ALU_ACK, 0);
      chk("rst dr_wr_1", DR_WR_1, 0);
      chk("rst dr_wr_2", DR_WR_2, 0);
      chk("rst dr_sel_wr_1", DR_SEL_WR_1, 0);
      chk("rst dr_sel_wr_2", DR_SEL_WR_2, 0);
      chk("rst dr_in_1", DR_IN_1, 0);
      chk("rst dr_in_2", DR_IN_2, 0);
      chk("rst unmark", UNMARK, 0);
      chk("rst mark_ovf", MARK_OVF, 0);
      model_reset();
      return;
    end
    chk("dr_wr_1", DR_WR_1, e_wr1);
    chk("dr_wr_2", DR_WR_2, e_wr2);
    chk("dr_sel_wr_1", DR_SEL_WR_1, e_sel1);
    chk("dr_sel_wr_2", DR_SEL_WR_2, e_sel2);
    chk("dr_in_1", DR_IN_1, e_in1);
    chk("dr_in_2", DR_IN_2, e_in2);
    chk("unmark", UNMARK, e_unmark);
    chk("mark_ovf", MARK_OVF, m_ovf);
    chk("mark_stall", MARK_STALL, m_cnt == 3);

    if (m_age == 4) ord = '{2, 0, 1};
    else            ord = '{0, 1, 2};
    ports = 2;
    retire = 0;
    for (int i = 0; i < 8; i++) used[i] = 0;
    for (int i = 0; i < 3; i++) begin
      int s;
      s = ord[i];
      g = 0;
      if (!pend[s]) continue;
      if (s == 0 && md_pair && rsel[0] != md_sel2) begin
        if (ports == 2) begin
          g = 1;
          w.sel = rsel[0]; w.data = rdat[0]; wq.push_back(w);
          w.sel = md_sel2; w.data = md_dat2; wq.push_back(w);
          used[rsel[0]] = 1; used[md_sel2] = 1;
          ports = 0;
        end
      end else if (ports > 0 && !used[rsel[s]]) begin
        g = 1;
        w.sel = rsel[s]; w.data = rdat[s]; wq.push_back(w);
        used[rsel[s]] = 1;
        ports--;
      end
      if (g) begin
        m_gnt[s] = 1;
        if (rret[s]) retire++;
      end
    end
    chk("md_ack", MD_ACK, m_gnt[0]);
    chk("ld_ack", LD_ACK, m_gnt[1]);
    chk("alu_ack", ALU_ACK, m_gnt[2]);

    e_wr1 = (wq.size() > 0);
    if (e_wr1) begin e_sel1 = wq[0].sel; e_in1 = wq[0].data; end
    e_wr2 = (wq.size() > 1);
    if (e_wr2) begin e_sel2 = wq[1].sel; e_in2 = wq[1].data; end

    iss = mark_issue;
    if (iss && m_cnt == 3) begin m_ovf = 1; iss = 0; end
    nxt = m_cnt + int'(iss) - retire;
    if (nxt < 0) begin nxt = 0; m_ovf = 1; end
    e_unmark = (m_cnt != 0 && nxt == 0);
    m_cnt = nxt;

    if (pend[2] && !m_gnt[2]) m_age = (m_age >= 4) ? 4 : m_age + 1;
    else                      m_age = 0;
  endtask

  task automatic step();
    if (auto_gen) gen();
    drive();
    @(negedge CLK);
    s_ack[0] = MD_ACK; s_ack[1] = LD_ACK; s_ack[2] = ALU_ACK;
    model_eval();
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) if (m_gnt[k]) pend[k] = 0;
  endtask

  task automatic set_req(input int k, input logic [2:0] s, input logic [31:0] d, input bit r);
    pend[k] = 1; rsel[k] = s; rdat[k] = d; rret[k] = r;
    if (k == 0) md_pair = 0;
  endtask

  int unmark_seen;

  initial begin
    RESET_N = 0;
    auto_gen = 0;
    mark_issue = 0;
    md_pair = 0; md_sel2 = '0; md_dat2 = '0;
    for (int k = 0; k < 3; k++) begin pend[k] = 0; rsel[k] = '0; rdat[k] = '0; rret[k] = 0; end
    model_reset();
    step();
    step();
    RESET_N = 1;

    // reset in the middle of traffic
    set_req(1, 3'd1, 32'hA5A5_0001, 0);
    set_req(2, 3'd2, 32'hA5A5_0002, 0);
    step();
    set_req(1, 3'd3, 32'hC0DE_0003, 0);
    set_req(2, 3'd4, 32'hC0DE_0004, 0);
    drive();
    RESET_N = 0;
    #1;
    chk("rst async dr_wr_1", DR_WR_1, 0);
    chk("rst async dr_wr_2", DR_WR_2, 0);
    chk("rst async dr_in_1", DR_IN_1, 0);
    chk("rst ld_ack held low", LD_ACK, 0);
    step();
    RESET_N = 1;
    step();
    chk("rst release ld_ack", s_ack[1], 1);
    chk("rst release alu_ack", s_ack[2], 1);
    chk("rst release dr_wr_1", DR_WR_1, 1);
    chk("rst release dr_wr_2", DR_WR_2, 1);

    // dual single writes
    set_req(1, 3'd3, 32'h1111_1111, 0);
    set_req(2, 3'd5, 32'h2222_2222, 0);
    step();
    chk("dual ld_ack", s_ack[1], 1);
    chk("dual alu_ack", s_ack[2], 1);
    chk("dual dr_wr_1", DR_WR_1, 1);
    chk("dual dr_sel_wr_1", DR_SEL_WR_1, 3);
    chk("dual dr_in_1", DR_IN_1, 32'h1111_1111);
    chk("dual dr_wr_2", DR_WR_2, 1);
    chk("dual dr_sel_wr_2", DR_SEL_WR_2, 5);
    chk("dual dr_in_2", DR_IN_2, 32'h2222_2222);
    step();
    chk("idle dr_wr_1", DR_WR_1, 0);
    chk("idle sel held", DR_SEL_WR_1, 3);

    // pair priority and ALU aging
    set_req(0, 3'd1, 32'hDDDD_0001, 0);
    md_pair = 1; md_sel2 = 3'd2; md_dat2 = 32'hDDDD_0002;
    set_req(2, 3'd6, 32'h6666_6666, 0);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c < 5) begin
        chk($sformatf("aging md_ack c%0d", c), s_ack[0], 1);
        chk($sformatf("aging alu_ack c%0d", c), s_ack[2], 0);
      end else begin
        chk("aging md_ack c5", s_ack[0], 0);
        chk("aging alu_ack c5", s_ack[2], 1);
        chk("aging alu on port 1", DR_SEL_WR_1, 6);
      end
      if (c == 1) begin
        chk("pair dr_wr_2", DR_WR_2, 1);
        chk("pair dr_sel_wr_2", DR_SEL_WR_2, 2);
        chk("pair dr_in_2", DR_IN_2, 32'hDDDD_0002);
      end
      if (!pend[0] && c < 5) pend[0] = 1;
    end
    step();
    chk("aging md after alu", s_ack[0], 1);
    md_pair = 0;
    step();

    // destination conflict
    set_req(1, 3'd4, 32'h4444_0001, 0);
    set_req(2, 3'd4, 32'h4444_0002, 0);
    step();
    chk("conflict ld_ack", s_ack[1], 1);
    chk("conflict alu_ack", s_ack[2], 0);
    chk("conflict dr_wr_2", DR_WR_2, 0);
    chk("conflict dr_in_1", DR_IN_1, 32'h4444_0001);
    step();
    chk("conflict alu next", s_ack[2], 1);
    chk("conflict alu data", DR_IN_1, 32'h4444_0002);
    step();

    // mark / retire counting
    mark_issue = 1;
    step();
    step();
    chk("stall after 2", MARK_STALL, 0);
    step();
    chk("stall after 3", MARK_STALL, 1);
    step();
    chk("ovf on 4th issue", MARK_OVF, 1);
    chk("stall stays", MARK_STALL, 1);
    mark_issue = 0;
    unmark_seen = 0;
    for (int r = 0; r < 3; r++) begin
      set_req(2, 3'(r), 32'hBEEF_0000 + 32'(r), 1);
      step();
      unmark_seen += int'(UNMARK);
      if (r == 2) begin
        chk("unmark with last wr", UNMARK, 1);
        chk("last retire dr_wr_1", DR_WR_1, 1);
      end
    end
    step();
    unmark_seen += int'(UNMARK);
    chk("unmark pulse count", 32'(unmark_seen), 1);
    chk("stall clear", MARK_STALL, 0);

    RESET_N = 0;
    step();
    RESET_N = 1;

    // simultaneous issue and retire
    mark_issue = 1;
    step();
    set_req(2, 3'd7, 32'h7777_7777, 1);
    step();
    mark_issue = 0;
    chk("simul no unmark", UNMARK, 0);
    chk("simul write", DR_WR_1, 1);
    step();
    chk("simul still no unmark", UNMARK, 0);
    set_req(2, 3'd0, 32'h0000_0007, 1);
    step();
    chk("simul count was 1", UNMARK, 1);
    chk("simul no ovf", MARK_OVF, 0);
    step();

    // random traffic
    auto_gen = 1;
    for (int i = 0; i < 3000; i++) begin
      RESET_N = ($urandom % 150 != 0);
      step();
    end
    RESET_N = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
